// File: rtl/turn_pkg.sv
// Shared types and constants for the turn sequencer: FSM state encoding,
// turn direction codes and H-bridge drive patterns.
package turn_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TURN    = 3'd1,
    OC_WAIT = 3'd2,
    DONE    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam logic [1:0] SHORT_RIGHT = 2'b01;
  localparam logic [1:0] SHORT_LEFT  = 2'b10;

  // IN[2:1] is wheel A, IN[4:3] is wheel B; per pair 01 fwd, 10 rev, 00 coast
  localparam logic [3:0] DRV_RIGHT = 4'b1001;
  localparam logic [3:0] DRV_LEFT  = 4'b0110;
  localparam logic [3:0] DRV_STOP  = 4'b0000;

  // Coast whichever wheel has already covered its tick target.
  function automatic logic [3:0] drive_mask(input logic [3:0] drv,
                                            input logic a_done,
                                            input logic b_done);
    return drv & {{2{~b_done}}, {2{~a_done}}};
  endfunction

endpackage

// File: rtl/turn_sequencer_enc_edge_sync.sv
// Encoder input conditioning: two-flop synchronizer on the raw pulse
// followed by a one-cycle rising-edge strobe.
module enc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  logic [2:0] sr;

  // sr[1:0] resynchronize the raw pin, sr[2] holds the previous synced value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= 3'b000;
    else     sr <= {sr[1:0], raw};
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/turn_sequencer.sv
// Short pivot-turn sequencer: drives the H-bridge for an encoder-measured
// turn, pauses/retries on overcurrent and latches a fault on repeated OC.
// Optional stall watchdog enabled by defining TURN_WATCHDOG_EN.
module turn_sequencer
  import turn_pkg::*;
#(
  parameter int SHORT_TICKS  = 40,
  parameter int TICK_W       = 12,
  parameter int OC_PAUSE_CYC = 50000,
  parameter int MAX_RETRY    = 3,
  parameter int WDOG_CYC     = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       turn_start,
  input  logic [1:0] encoder_turn,
  input  logic       encA,
  input  logic       encB,
  input  logic       enA_OC,
  input  logic       enB_OC,
  output logic [4:1] IN,
  output logic       T_C,
  output logic       busy,
  output logic       fault
);

  localparam int PAUSE_W = $clog2(OC_PAUSE_CYC + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [TICK_W-1:0]  TICK_TGT   = TICK_W'(SHORT_TICKS);
  localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(OC_PAUSE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  state_t             state, state_nxt;
  logic               dir_right;
  logic [TICK_W-1:0]  cnt_a, cnt_b;
  logic [PAUSE_W-1:0] pause_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               tick_a, tick_b;
  logic               a_full, b_full, oc, counting;
  logic               start_turn, load_pause, inc_retry, wdog_hit;

  enc_edge_sync u_sync_a (.clk(clk), .rst(rst), .raw(encA), .rise(tick_a));
  enc_edge_sync u_sync_b (.clk(clk), .rst(rst), .raw(encB), .rise(tick_b));

  assign a_full   = (cnt_a == TICK_TGT);
  assign b_full   = (cnt_b == TICK_TGT);
  assign oc       = enA_OC | enB_OC;
  assign counting = (state == TURN) || (state == OC_WAIT);

`ifdef TURN_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_TGT = WDOG_W'(WDOG_CYC);
  logic [WDOG_W-1:0] wdog_cnt;

  // Cycles since the last tick while driving; held during the OC pause
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       wdog_cnt <= '0;
    else if (start_turn)                           wdog_cnt <= '0;
    else if (state == TURN && (tick_a || tick_b))  wdog_cnt <= '0;
    else if (state == TURN && wdog_cnt != WDOG_TGT) wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_hit = (wdog_cnt == WDOG_TGT);
`else
  assign wdog_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort beats overcurrent beats completion
  always_comb begin
    state_nxt  = state;
    start_turn = 1'b0;
    load_pause = 1'b0;
    inc_retry  = 1'b0;
    case (state)
      IDLE: begin
        if (turn_start && (encoder_turn == SHORT_RIGHT || encoder_turn == SHORT_LEFT)) begin
          start_turn = 1'b1;
          state_nxt  = TURN;
        end
      end
      TURN: begin
        if (!turn_start) begin
          state_nxt = IDLE;
        end else if (oc) begin
          if (retry_cnt == RETRY_MAX) begin
            state_nxt = FAULT;
          end else begin
            inc_retry  = 1'b1;
            load_pause = 1'b1;
            state_nxt  = OC_WAIT;
          end
        end else if (wdog_hit) begin
          state_nxt = FAULT;
        end else if (a_full && b_full) begin
          state_nxt = DONE;
        end
      end
      OC_WAIT: begin
        if (!turn_start) begin
          state_nxt = IDLE;
        end else if (pause_cnt == '0) begin
          if (oc) load_pause = 1'b1;
          else    state_nxt  = TURN;
        end
      end
      DONE: begin
        if (!turn_start) state_nxt = IDLE;
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Direction latch and per-wheel saturating tick counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_right <= 1'b0;
      cnt_a     <= '0;
      cnt_b     <= '0;
    end else if (start_turn) begin
      dir_right <= (encoder_turn == SHORT_RIGHT);
      cnt_a     <= '0;
      cnt_b     <= '0;
    end else if (counting) begin
      if (tick_a && !a_full) cnt_a <= cnt_a + 1'b1;
      if (tick_b && !b_full) cnt_b <= cnt_b + 1'b1;
    end
  end

  // Overcurrent pause timer and retry counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_cnt <= '0;
      retry_cnt <= '0;
    end else begin
      if (load_pause)                               pause_cnt <= PAUSE_LOAD;
      else if (state == OC_WAIT && pause_cnt != '0) pause_cnt <= pause_cnt - 1'b1;
      if (start_turn)     retry_cnt <= '0;
      else if (inc_retry) retry_cnt <= retry_cnt + 1'b1;
    end
  end

  // Registered outputs, decoded from the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IN    <= DRV_STOP;
      T_C   <= 1'b0;
      busy  <= 1'b0;
      fault <= 1'b0;
    end else begin
      IN    <= (state == TURN) ? drive_mask(dir_right ? DRV_RIGHT : DRV_LEFT, a_full, b_full)
                               : DRV_STOP;
      T_C   <= (state == DONE);
      busy  <= counting;
      fault <= (state == FAULT);
    end
  end

endmodule
